// File: rtl/demux_dispatcher_if.sv
// Stream bundle for the 1-to-2 dispatcher: one valid/ready input and two valid/ready outputs.
// The dispatcher uses the slave modport, and the producer/consumer side uses the master modport.
interface demux_dispatcher_if #(
  parameter int W = 8
);
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] i_data;
  logic         i_dst;
  logic         o0_valid;
  logic         o0_ready;
  logic [W-1:0] o0_data;
  logic         o1_valid;
  logic         o1_ready;
  logic [W-1:0] o1_data;

  modport slave (
    input  i_valid, i_data, i_dst, o0_ready, o1_ready,
    output i_ready, o0_valid, o0_data, o1_valid, o1_data
  );

  modport master (
    output i_valid, i_data, i_dst, o0_ready, o1_ready,
    input  i_ready, o0_valid, o0_data, o1_valid, o1_data
  );
endinterface

// File: rtl/demux_dispatcher.sv
// Steers each input word to one of two one-entry output buffers, chosen by i_dst or round-robin.
// Each output has its own saturating accepted-word counter.
module demux_dispatcher #(
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  demux_dispatcher_if.slave         bus,
  output logic                      rr_ptr,
  output logic [7:0]                cnt0,
  output logic [7:0]                cnt1,
  output logic                      busy
);

  logic         o0_valid_q;
  logic         o1_valid_q;
  logic [W-1:0] o0_data_q;
  logic [W-1:0] o1_data_q;
  logic         tgt;
  logic         tgt_valid;
  logic         tgt_ready;
  logic         accept;
  logic         load0;
  logic         load1;
  logic         v0_next;
  logic         v1_next;

  // The ready path looks only at the chosen buffer, so a stall on one side never blocks the other.
  always_comb begin
    tgt       = mode ? rr_ptr : bus.i_dst;
    tgt_valid = tgt ? o1_valid_q : o0_valid_q;
    tgt_ready = tgt ? bus.o1_ready : bus.o0_ready;
    bus.i_ready = !rst & en & (!tgt_valid | tgt_ready);
    accept    = bus.i_valid & bus.i_ready;
    load0     = accept & !tgt;
    load1     = accept & tgt;
    v0_next   = load0 | (o0_valid_q & !bus.o0_ready);
    v1_next   = load1 | (o1_valid_q & !bus.o1_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o0_valid_q <= 1'b0;
      o1_valid_q <= 1'b0;
      o0_data_q  <= '0;
      o1_data_q  <= '0;
      rr_ptr     <= 1'b0;
      cnt0       <= 8'd0;
      cnt1       <= 8'd0;
      busy       <= 1'b0;
    end else begin
      o0_valid_q <= v0_next;
      o1_valid_q <= v1_next;
      busy       <= v0_next | v1_next;
      if (load0) begin
        o0_data_q <= bus.i_data;
      end
      if (load1) begin
        o1_data_q <= bus.i_data;
      end
      if (load0 && cnt0 != 8'hFF) begin
        cnt0 <= cnt0 + 8'd1;
      end
      if (load1 && cnt1 != 8'hFF) begin
        cnt1 <= cnt1 + 8'd1;
      end
      if (accept && mode) begin
        rr_ptr <= ~rr_ptr;
      end
    end
  end

  assign bus.o0_valid = o0_valid_q;
  assign bus.o1_valid = o1_valid_q;
  assign bus.o0_data  = o0_data_q;
  assign bus.o1_data  = o1_data_q;

endmodule

// File: doc/demux_dispatcher.md
# demux_dispatcher

Sequential 1-to-2 stream dispatcher built around the 1-to-2 demux datapath. It accepts a valid/ready input stream and steers each word to output 0 or 1, using either a per-word destination bit or a round-robin pointer. Each output has a one-entry holding register, so a stalled output does not block traffic headed to the other output. Per-output saturating word counters support bring-up and debug.

## Interface

Parameters:
- W, 8, data width in bits (W ≥ 1)

Ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock
- rst, in, 1, synchronous active-high reset
- en, in, 1, dispatcher enable; when 0, no new words are accepted
- mode, in, 1, 0 = steer by i_dst; 1 = round-robin
- i_valid, in, 1, input word valid
- i_ready, out, 1, dispatcher can accept the input word
- i_data, in, W, input word
- i_dst, in, 1, destination select; used only when mode = 0
- o0_valid, out, 1, output 0 holds a word
- o0_ready, in, 1, downstream 0 accepts
- o0_data, out, W, output 0 word
- o1_valid, out, 1, output 1 holds a word
- o1_ready, in, 1, downstream 1 accepts
- o1_data, out, W, output 1 word
- rr_ptr, out, 1, next round-robin target
- cnt0, out, 8, words accepted for output 0; saturates at 255
- cnt1, out, 8, words accepted for output 1; saturates at 255
- busy, out, 1, equals o0_valid | o1_valid

## Operation

- **Target:** t = mode ? rr_ptr : i_dst.
- **i_ready:** i_ready = !rst & en & (!ot_valid | ot_ready).
  - Combinational in en, mode, i_dst, rr_ptr and the target's o_valid/o_ready.
  - Never a function of i_valid.
- **Accept:** a word is accepted when i_valid & i_ready at the clock edge. On accept:
  - buffer t loads i_data and sets ot_valid = 1;
  - cnt_t increments, holding at 255;
  - if mode = 1, rr_ptr toggles.
- **Drain:** a buffer clears its valid when o_valid & o_ready and no load to the same buffer occurs that edge.
- **Drain and load on the same buffer, same edge:** valid stays 1 and data takes the new word. This gives full throughput.
- **Output stability:** while ox_valid = 1 and ox_ready = 0, ox_data and ox_valid hold.
- **Output independence:** the two output buffers never interact. A stall on one output never blocks words aimed at the other.
- **Mode behaviour:**
  - mode = 0: rr_ptr holds its value.
  - Mode changes take effect for the next accept. rr_ptr is not reset by a mode change.
- **en = 0:**
  - i_ready = 0.
  - Buffered words still drain normally.
  - Counters and rr_ptr hold.
- **Reset values:** every output reads 0 (o0_valid, o1_valid, o0_data, o1_data, rr_ptr, cnt0, cnt1, busy, i_ready). Buffered words are discarded, even mid-transfer.
- **Counters:** cnt0 and cnt1 are cleared only by rst.

## Timing

- **Latency:** 1 cycle. A word accepted at edge k is visible on ox_data/ox_valid after edge k.
- **Throughput:** 1 word/cycle while the target's downstream ready is held high.
- **Round-robin sustained rate:** 1 word/cycle total (alternating outputs).
- **Round-robin stall:** if the current rr target is stalled, i_ready = 0. The dispatcher does not skip to the other output, so ordering stays strictly alternating.
- **Registered outputs:** ox_valid, ox_data, rr_ptr, cnt0, cnt1 and busy come from registers.
- **Combinational output:** i_ready only.
- **Reset timing:** rst is sampled at the edge. With rst high at edge k, all state is cleared after edge k. The first accept is possible at edge k+1 if rst is low then.

## Test plan

1. **Reset:** hold rst = 1 for 2 cycles with i_valid = 1, en = 1, data 0xFF.
   - i_ready = 0 throughout.
   - After release: all valids 0, cnt0 = cnt1 = 0, rr_ptr = 0.
2. **Destination mode:** mode = 0, both readies 1. Send 0xA5 (dst 0), then 0x3C (dst 1), back to back.
   - o0 = 0xA5 one cycle after its accept; o1 = 0x3C on the next cycle.
   - cnt0 = 1, cnt1 = 1; rr_ptr stays 0.
3. **Round-robin:** mode = 1. Stream words 1, 2, 3, 4 with both readies 1.
   - o0 sees 1 then 3; o1 sees 2 then 4.
   - Final rr_ptr = 0; cnt0 = cnt1 = 2.
4. **Backpressure isolation:** mode = 0, o0_ready = 0. Send 0x11 (dst 0), then 0x22 (dst 0).
   - o0 holds 0x11 stable; i_ready = 0 while 0x22 is presented.
   - Then present 0x33 (dst 1): accepted immediately and appears on o1.
   - Raise o0_ready: 0x22 is accepted the same cycle 0x11 drains, and o0_valid stays 1.
5. **Saturation:** send 300 words to output 1.
   - cnt1 = 255 and holds; cnt0 = 0.
6. **Enable and mid-operation reset:** with o1 holding a word and o1_ready = 0, drop en.
   - i_ready = 0 and busy = 1.
   - Assert rst for 1 cycle: o1_valid = 0, busy = 0, counters = 0 the cycle after.
